switch_debounce_conditioner: RTL and testbench

- Input-conditioning stage placed directly upstream of the light show controller.
- Takes raw, asynchronous, bouncing board switches (3 colour, speed, pattern) and produces clean, clock-synchronous debounced levels plus one-cycle rise/fall pulses.
- The controller's colour, speed and pattern inputs are driven from these outputs.
- Channels are independent; one shared clock domain.

---
 rtl/switch_debounce_conditioner.sv | 144 ++++++++++++++
 tb/tb_switch_debounce_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_conditioner.sv
`default_nettype none
// ============================================================================
// switch_debounce_conditioner: two-flop synchroniser plus per-channel debounce
// FSM producing registered levels and one-cycle rise/fall pulses. Rev 1.0
// ============================================================================
module switch_debounce_conditioner #(
    parameter int NUM_SW          = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              any_event
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] w_level_nxt;
    logic [NUM_SW-1:0] w_rise_nxt;
    logic [NUM_SW-1:0] w_fall_nxt;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_rise;
        logic             w_fall;
        logic             w_s;

        assign w_s = r_sync2[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= STABLE_LO;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rise      = 1'b0;
            w_fall      = 1'b0;
            case (r_state)
                STABLE_LO: begin
                    w_cnt_nxt = '0;
                    if (w_s) begin
                        // A single-cycle qualification window accepts immediately
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = STABLE_HI;
                            w_rise      = 1'b1;
                        end else begin
                            w_state_nxt = WAIT_HI;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                WAIT_HI: begin
                    if (!w_s) begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = '0;
                        w_rise      = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                STABLE_HI: begin
                    w_cnt_nxt = '0;
                    if (!w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = STABLE_LO;
                            w_fall      = 1'b1;
                        end else begin
                            w_state_nxt = WAIT_LO;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                WAIT_LO: begin
                    if (w_s) begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = '0;
                        w_fall      = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_level_nxt[i] = (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
        assign w_rise_nxt[i]  = w_rise;
        assign w_fall_nxt[i]  = w_fall;
    end

    // Outputs are re-registered from next-state decode so pulses align with the new level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            sw_level  <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            any_event <= 1'b0;
        end else begin
            r_sync1   <= sw_raw;
            r_sync2   <= r_sync1;
            sw_level  <= w_level_nxt;
            sw_rise   <= w_rise_nxt;
            sw_fall   <= w_fall_nxt;
            any_event <= |(w_rise_nxt | w_fall_nxt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_conditioner.sv
`default_nettype none
// ============================================================================
// tb_switch_debounce_conditioner: directed + random stimulus on D=4 and D=1
// instances, checked every cycle against a run-length reference model. Rev 1.0
// ============================================================================
module tb_switch_debounce_conditioner;

    localparam int NUM_SW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_SW-1:0] raw = '0;

    logic [NUM_SW-1:0] lvl4, rise4, fall4;
    logic              ev4;
    logic [NUM_SW-1:0] lvl1, rise1, fall1;
    logic              ev1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    switch_debounce_conditioner #(.NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .sw_raw(raw),
        .sw_level(lvl4), .sw_rise(rise4), .sw_fall(fall4), .any_event(ev4)
    );

    switch_debounce_conditioner #(.NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_raw(raw),
        .sw_level(lvl1), .sw_rise(rise1), .sw_fall(fall1), .any_event(ev1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a change is accepted once the synchronised input has
    // disagreed with the accepted level for D consecutive cycles.
    int                m_d [2] = '{4, 1};
    logic [NUM_SW-1:0] m_s1 [2];
    logic [NUM_SW-1:0] m_s2 [2];
    logic [NUM_SW-1:0] m_lvl [2];
    logic [NUM_SW-1:0] m_rise [2];
    logic [NUM_SW-1:0] m_fall [2];
    int                m_run [2][NUM_SW];
    bit                m_valid = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0;
                m_rise[k] = '0; m_fall[k] = '0;
                for (int b = 0; b < NUM_SW; b++) m_run[k][b] = 0;
            end else begin
                m_rise[k] = '0;
                m_fall[k] = '0;
                for (int b = 0; b < NUM_SW; b++) begin
                    if (m_s2[k][b] != m_lvl[k][b]) begin
                        m_run[k][b] = m_run[k][b] + 1;
                        if (m_run[k][b] == m_d[k]) begin
                            m_lvl[k][b] = ~m_lvl[k][b];
                            if (m_lvl[k][b]) m_rise[k][b] = 1'b1;
                            else             m_fall[k][b] = 1'b1;
                            m_run[k][b] = 0;
                        end
                    end else begin
                        m_run[k][b] = 0;
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw;
            end
        end
        if (!rst_n) m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("d4_level", 32'(lvl4), 32'(m_lvl[0]));
            chk("d4_rise",  32'(rise4), 32'(m_rise[0]));
            chk("d4_fall",  32'(fall4), 32'(m_fall[0]));
            chk("d4_any",   32'(ev4), 32'(|(m_rise[0] | m_fall[0])));
            chk("d1_level", 32'(lvl1), 32'(m_lvl[1]));
            chk("d1_rise",  32'(rise1), 32'(m_rise[1]));
            chk("d1_fall",  32'(fall1), 32'(m_fall[1]));
            chk("d1_any",   32'(ev1), 32'(|(m_rise[1] | m_fall[1])));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int nz;
        int cnt;

        // Reset, then idle: nothing may move
        raw   = '0;
        rst_n = 1'b0;
        settle(2);
        chk("reset_level4", 32'(lvl4), 32'h0);
        chk("reset_events", 32'({rise4, fall4, ev4, rise1, fall1, ev1}), 32'h0);
        rst_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({lvl4, rise4, fall4, ev4, lvl1, rise1, fall1, ev1} != '0) nz++;
        end
        chk("idle_all_zero", 32'(nz), 32'h0);

        // Clean rise on channel 3: accepted on the 6th edge for D=4, 3rd for D=1
        raw[3] = 1'b1;
        cnt = 0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (ev4) cnt++;
            if (e == 2) chk("d1_rise3_early", 32'(rise1), 32'h0);
            if (e == 3) chk("d1_rise3_edge3", 32'(rise1), 32'h08);
            if (e == 5) chk("d4_level3_e5", 32'(lvl4[3]), 32'h0);
            if (e == 6) chk("d4_level_rise3_e6", 32'({lvl4, rise4}), 32'({5'b01000, 5'b01000}));
            if (e == 7) chk("d4_rise3_e7", 32'({lvl4[3], rise4[3]}), 32'b10);
        end
        chk("d4_any_once", 32'(cnt), 32'd1);
        raw[3] = 1'b0;
        settle(10);

        // Bounce on channel 4, then held high
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            raw[4] = (i % 2 == 0);
            tick();
            if (rise4[4]) cnt++;
        end
        raw[4] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6 && rise4[4]) cnt++;
            if (e == 6) chk("d4_rise4_after_bounce", 32'(rise4), 32'h10);
        end
        chk("d4_no_bounce_rise", 32'(cnt), 32'd0);
        settle(4);

        // Simultaneous rises on channels 0 and 2
        raw[2:0] = 3'b101;
        cnt = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (ev4) cnt++;
            if (e == 6) chk("d4_rise_101", 32'(rise4), 32'h05);
        end
        chk("d4_any_simul_once", 32'(cnt), 32'd1);

        // Channel 0: 3-cycle low glitch rejected, then a held fall accepted
        cnt = 0;
        raw[0] = 1'b0; settle(3);
        raw[0] = 1'b1; tick();
        raw[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (fall4[0]) cnt++;
            if (e == 5) chk("d4_fall0_e5", 32'({lvl4[0], fall4[0]}), 32'b10);
            if (e == 6) chk("d4_fall0_e6", 32'({lvl4[0], fall4[0]}), 32'b01);
        end
        chk("d4_fall0_once", 32'(cnt), 32'd1);
        settle(4);

        // Channel 1 held high through a reset taken while waiting
        raw[1] = 1'b1;
        settle(3);
        rst_n = 1'b0;
        tick();
        chk("rst_level4", 32'(lvl4), 32'h0);
        chk("rst_nofall", 32'({fall4, fall1}), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 3) chk("d1_rise1_after_rst", 32'(rise1[1]), 32'h1);
            if (e == 5) chk("d4_rise1_e5", 32'(rise4[1]), 32'h0);
            if (e == 6) chk("d4_rise1_e6", 32'(rise4[1]), 32'h1);
        end

        // Random bouncy activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NUM_SW; b++)
                if ($urandom_range(7) == 0) raw[b] = ~raw[b];
            rst_n = ($urandom_range(399) != 0);
            tick();
        end
        rst_n = 1'b1;
        settle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
